// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into one-cycle
// press / release / click / long / repeat event pulses plus a held flag.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   btn_level     debounced, synchronous button level (1 = pressed)
//   press_pulse   one cycle on an accepted press
//   release_pulse one cycle on release from PRESSED or HOLD_LONG
//   click_pulse   one cycle on release before the long threshold
//   long_pulse    one cycle when the long threshold is reached
//   repeat_pulse  one cycle every REPEAT_CYCLES while long-held
//   held          high while PRESSED or HOLD_LONG
module button_event_gen #(
   parameter int unsigned LONG_CYCLES   = 100_000_000,
   parameter int unsigned REPEAT_CYCLES = 20_000_000,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned CNT_W         = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam logic [1:0] ST_LOCKOUT = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_PRESSED = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             click_q, click_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      click_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         // A button held through reset must be seen released first.
         ST_LOCKOUT: begin
            if (!btn_level) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (btn_level) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
               press_d = 1'b1;
            end
         end
         ST_PRESSED: begin
            // Release wins over a coincident threshold match.
            if (!btn_level) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
               click_d   = 1'b1;
            end else if (cnt_q == LONG_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (!btn_level) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (cnt_q == REP_LAST) begin
               cnt_d    = '0;
               repeat_d = REPEAT_EN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOCKOUT;
            cnt_d   = '0;
         end
      endcase
      held_d = (state_d == ST_PRESSED) || (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_LOCKOUT;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         click_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         click_q   <= click_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign click_pulse   = click_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: drives two button_event_gen instances (repeat on/off)
// with directed and random button activity against an arithmetic event model.
module tb_button_event_gen;

   localparam int L = 10;
   localparam int R = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b1;

   logic a_press, a_rel, a_click, a_long, a_rep, a_held;
   logic b_press, b_rel, b_click, b_long, b_rep, b_held;

   int checks = 0;
   int failures = 0;

   int  edges = 0;
   bit  m_lock = 1'b1;
   bit  m_pr = 1'b0;
   int  tp = 0;
   bit  e_press, e_rel, e_click, e_long, e_rep, e_held;

   always #5 clk = ~clk;

   button_event_gen #(
      .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1), .CNT_W(8)
   ) dut_a (
      .clk(clk), .rst(rst), .btn_level(btn),
      .press_pulse(a_press), .release_pulse(a_rel),
      .click_pulse(a_click), .long_pulse(a_long),
      .repeat_pulse(a_rep), .held(a_held)
   );

   button_event_gen #(
      .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0), .CNT_W(8)
   ) dut_b (
      .clk(clk), .rst(rst), .btn_level(btn),
      .press_pulse(b_press), .release_pulse(b_rel),
      .click_pulse(b_click), .long_pulse(b_long),
      .repeat_pulse(b_rep), .held(b_held)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=%b expected=%b",
                tag, edges, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("a_press", a_press, e_press);
      chk("a_release", a_rel, e_rel);
      chk("a_click", a_click, e_click);
      chk("a_long", a_long, e_long);
      chk("a_repeat", a_rep, e_rep);
      chk("a_held", a_held, e_held);
      chk("b_press", b_press, e_press);
      chk("b_release", b_rel, e_rel);
      chk("b_click", b_click, e_click);
      chk("b_long", b_long, e_long);
      chk("b_repeat", b_rep, 1'b0);
      chk("b_held", b_held, e_held);
   endtask

   // Event model: everything derives from edges elapsed since the press.
   task automatic model(input bit b);
      int el;
      e_press = 0; e_rel = 0; e_click = 0; e_long = 0; e_rep = 0;
      if (m_lock) begin
         if (!b) m_lock = 0;
      end else if (!m_pr) begin
         if (b) begin
            m_pr = 1; tp = edges; e_press = 1;
         end
      end else begin
         el = edges - tp;
         if (!b) begin
            m_pr = 0; e_rel = 1; e_click = (el <= L);
         end else begin
            e_long = (el == L);
            e_rep = (el > L) && (((el - L) % R) == 0);
         end
      end
      e_held = m_pr;
   endtask

   task automatic step(input bit b);
      btn = b;
      @(posedge clk);
      edges++;
      model(b);
      @(negedge clk);
      chk_all();
   endtask

   task automatic run(input bit b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      m_lock = 1; m_pr = 0;
      e_press = 0; e_rel = 0; e_click = 0;
      e_long = 0; e_rep = 0; e_held = 0;
      chk_all();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Held through reset, then released and re-pressed.
      @(negedge clk);
      @(negedge clk);
      e_press = 0; e_rel = 0; e_click = 0;
      e_long = 0; e_rep = 0; e_held = 0;
      chk_all();
      rst = 1'b0;
      run(1, 30);
      run(0, 1);
      run(1, 3);
      run(0, 2);
      // Short click.
      run(1, 5);
      run(0, 3);
      // Long hold with repeats.
      run(1, 25);
      run(0, 2);
      // Release exactly at threshold, and one past it.
      run(1, 10);
      run(0, 1);
      run(1, 11);
      run(0, 1);
      // Back-to-back press right after release.
      run(1, 2);
      run(0, 1);
      run(1, 1);
      run(0, 1);
      // Reset mid HOLD_LONG with button still down.
      run(1, 12);
      pulse_reset();
      run(1, 6);
      run(0, 2);
      // Random activity with occasional resets.
      for (int k = 0; k < 120; k++) begin
         run(1, $urandom_range(1, 30));
         if ($urandom_range(0, 9) == 0) pulse_reset();
         run(0, $urandom_range(1, 4));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Converts the debounced, clock-synchronous button level into one-cycle event pulses: press, release, short click, long press and auto-repeat.
- Sits directly downstream of the button debouncer, one instance per physical button.
- Its pulses drive the matrix-calculator menu and input FSMs.
- The input is already synchronized and glitch-free, so no extra synchronizer stages are used.

Parameters:
- LONG_CYCLES, 100_000_000: cycles from press_pulse to long_pulse (1 s at 100 MHz); legal range >= 2.
- REPEAT_CYCLES, 20_000_000: cycles between successive repeat_pulse while long-held (200 ms); legal range >= 1.
- REPEAT_EN, 1: 1 = generate repeat_pulse in HOLD_LONG; 0 = never assert repeat_pulse.
- CNT_W, 27: counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES) - 1.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- btn_level  input  1  debounced button level, 1 = pressed
- press_pulse  output  1  one-cycle pulse on accepted press
- release_pulse  output  1  one-cycle pulse on any release from PRESSED or HOLD_LONG
- click_pulse  output  1  one-cycle pulse on release before the long threshold (same cycle as release_pulse)
- long_pulse  output  1  one-cycle pulse when the long threshold is reached
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while in HOLD_LONG
- held  output  1  1 while state is PRESSED or HOLD_LONG

Behaviour:
- All outputs are registered. Reset values: all pulses 0, held 0, cnt 0, state LOCKOUT.
- States: LOCKOUT, IDLE, PRESSED, HOLD_LONG. Each pulse output is high for exactly one cycle per event. Pulses are computed from the state and btn_level sampled at the same edge.
- LOCKOUT:
  - btn_level=0 -> IDLE, no pulse.
  - Otherwise stay in LOCKOUT.
  - A button held through reset never produces events until it is released.
- IDLE:
  - btn_level=1 -> PRESSED, cnt<=0, press_pulse<=1.
  - Call the cycle in which press_pulse is high cycle T.
- PRESSED:
  - btn_level=0 -> IDLE, release_pulse<=1, click_pulse<=1.
  - Else if cnt==LONG_CYCLES-1 -> HOLD_LONG, cnt<=0, long_pulse<=1. long_pulse is therefore high in cycle T+LONG_CYCLES.
  - Else cnt<=cnt+1.
- HOLD_LONG:
  - btn_level=0 -> IDLE, release_pulse<=1, click_pulse stays 0, cnt<=0.
  - Else if cnt==REPEAT_CYCLES-1 -> cnt<=0, repeat_pulse<=REPEAT_EN.
  - Else cnt<=cnt+1.
  - The nth repeat (n>=1) is high in cycle T+LONG_CYCLES+n*REPEAT_CYCLES.
- Release has priority over threshold when both occur at the same edge. No long_pulse or repeat_pulse is emitted in that case.
- held<=1 on entry to PRESSED and stays 1 through HOLD_LONG. It goes to 0 in the same cycle as release_pulse.
- Back-to-back activity: a press on the edge after the release edge (IDLE, level 1) is accepted normally. The minimum press/release spacing is one cycle.
- cnt never wraps: it is cleared on every state entry and at each threshold match.
- rst asserted mid-operation: immediate asynchronous return to reset values. No release_pulse is emitted for the aborted press.
- At most one of press/long/repeat/release asserts in any cycle. click_pulse only coincides with release_pulse.

Test Plan (LONG_CYCLES=10, REPEAT_CYCLES=4, REPEAT_EN=1 unless stated):
- Short click: btn_level high 5 cycles from IDLE then low -> press_pulse at T; release_pulse and click_pulse together at T+5; held high T..T+4; no long_pulse.
- Long hold with repeat: btn_level high 25 cycles -> press at T, long_pulse at T+10, repeat_pulse at T+14, T+18, T+22; release_pulse at T+25 with click_pulse=0.
- Release exactly at threshold: btn_level falls on the edge producing cycle T+10 -> release_pulse and click_pulse at T+10; long_pulse never asserted.
- Held through reset: btn_level=1 while rst pulses, stays high 30 cycles, then low 1 cycle, then high -> no pulses until the re-press; then press_pulse one cycle after the rising edge.
- REPEAT_EN=0, hold 25 cycles -> long_pulse at T+10; repeat_pulse never asserts; release_pulse at T+25.
- Reset mid-HOLD_LONG: rst asserted at T+12 -> all outputs 0 asynchronously; no release_pulse afterward; state LOCKOUT until btn_level is seen low.
